rv32_run_monitor: RTL and testbench
===================================

// Module: rv32_run_monitor
// PURPOSE
//  Parametrised run monitor for the rv32 cores. Watches the retire stream (PC + valid) and data-store traffic.
//  Decides run termination: pass, fail or timeout. Counts cycles and retired instructions.
//  Keeps a circular trace of the last TRACE_DEPTH retired PCs for post-mortem readout.
//  Instantiated next to the core top in simulation benches. Synthesizable, so it can also be used on an FPGA bring-up.
// PARAMETERS
//  XLEN           32            PC / address / data width
//  CNT_W          32            cycle_count / instret_count width
//  TIMEOUT_CYCLES 5000          cycles after reset deassert before timeout; 0 = disabled
//  USE_HALT_PC    0             1 = retire of HALT_PC ends run as pass
//  HALT_PC        32'h0000_0000 halt address (used only if USE_HALT_PC)
//  STUCK_LIMIT    4             consecutive retires of same PC => self-loop halt (pass); 0 = disabled
//  TOHOST_ADDR    32'h0000_1000 store address decoded as tohost
//  TRACE_DEPTH    8             PC trace entries, power of 2, >=2
// PORTS
//  clk            in   1                   core clock
//  reset          in   1                   synchronous, active-high
//  retire_valid   in   1                   one instruction retires this cycle
//  retire_pc      in   XLEN                PC of retiring instruction
//  store_valid    in   1                   data store issued this cycle
//  store_addr     in   XLEN                store byte address
//  store_data     in   XLEN                store write data
//  trace_idx      in   $clog2(TRACE_DEPTH) 0 = most recent retired PC
//  trace_pc       out  XLEN                trace entry at trace_idx (combinational read)
//  trace_count    out  $clog2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH
//  running        out  1                   monitor in RUN state
//  done           out  1                   run terminated (sticky until reset)
//  status         out  2                   0 none, 1 pass, 2 fail, 3 timeout
//  fail_code      out  XLEN                tohost_data>>1 on fail, else 0
//  cycle_count    out  CNT_W               cycles spent in RUN
//  instret_count  out  CNT_W               retires counted in RUN
// BEHAVIOUR
//  Reset (sync)
//   - All outputs 0. state=IDLE. Trace pointer and count 0; trace RAM contents don't care.
//   - reset wins over every other input in the same cycle.
//   - Reset mid-run or after done returns the monitor to IDLE and clears all outputs next edge.
//  FSM: IDLE -> RUN -> DONE
//   - IDLE -> RUN on the first cycle with reset low. cycle_count starts at 0 in that cycle.
//   - In RUN, every edge: cycle_count+=1 (wraps at 2^CNT_W). instret_count+=retire_valid.
//   - On a retire, push retire_pc into trace[wr_ptr]; wr_ptr wraps modulo TRACE_DEPTH.
//     trace_pc = trace[(wr_ptr-1-trace_idx) mod TRACE_DEPTH].
//   - Termination events, evaluated on the same edge. Priority when simultaneous:
//     1 tohost: store_valid && store_addr==TOHOST_ADDR && store_data[0]
//       -> data==1: pass; else fail, fail_code=data>>1
//     2 halt: USE_HALT_PC && retire_valid && retire_pc==HALT_PC -> pass
//     3 stuck: the STUCK_LIMIT-th consecutive retire with an identical PC -> pass
//       (streak counter resets on a different PC; non-retire cycles don't break the streak)
//     4 timeout: TIMEOUT_CYCLES!=0 && cycle_count==TIMEOUT_CYCLES-1 -> timeout
//   - The event cycle's counts and trace push are included; done/status are visible the cycle after the event (1-cycle latency).
//   - Stores with store_data[0]==0 to TOHOST_ADDR are ignored.
//   - DONE is absorbing: counters, trace, status and fail_code are frozen; inputs are ignored; trace stays readable.
//   - running=1 only in RUN; done=1 only in DONE.
// STRUCTURE
//  - Package rv32_mon_pkg:
//    - typedef enum logic[1:0] {ST_NONE, ST_PASS, ST_FAIL, ST_TIMEOUT} mon_status_e
//    - typedef enum {MON_IDLE, MON_RUN, MON_DONE} mon_state_e
//    - default TOHOST_ADDR constant
//  - One sub-module: rv32_pc_trace_buf (circular write, indexed newest-relative read, count).
//  - FSM, counters and event decode live in the top.
// TESTING
//  1 Reset held 3 cycles mid-run after 20 retires -> all outputs 0, trace_count=0, running=1 on the first cycle after release.
//  2 Retire PCs 0,4,8..; store 1 to TOHOST_ADDR at cycle 50 -> status=1, done next cycle, fail_code=0.
//  3 Store 32'h15 to tohost -> status=2, fail_code=10. Later stores and retires leave all outputs frozen.
//  4 STUCK_LIMIT=4; retire PC 0x40 four times (bubbles between) -> pass. Streak of 3 then 0x44 -> no halt.
//  5 TIMEOUT_CYCLES=100, no events -> status=3 with cycle_count=100. Tohost store on the final cycle -> status=1 (priority).
//  6 TRACE_DEPTH=8; 11 retires PC=4*k -> trace_count=8, idx0=40, idx7=12 (wrap correct).

Source files
------------

// File: rtl/rv32_mon_pkg.sv
// Shared types and constants for the rv32 run monitor.
package rv32_mon_pkg;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_status_e;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_RUN  = 2'd1,
        MON_DONE = 2'd2
    } mon_state_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/rv32_pc_trace_buf.sv
// Circular buffer of retired PCs; read side is indexed relative to the newest entry.
module rv32_pc_trace_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [XLEN-1:0]  push_pc,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [XLEN-1:0]  rd_pc,
    output logic [IDX_W:0]   count
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (count != FULL) begin
                count <= count + (IDX_W+1)'(1);
            end
        end
    end

    // Storage carries no reset; an empty buffer reads as zero instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_pc;
        end
    end

    assign rd_ptr = wr_ptr - IDX_W'(1) - rd_idx;
    assign rd_pc  = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rv32_run_monitor.sv
// Run monitor: decides pass/fail/timeout from the retire and store streams,
// counts cycles and retires, and keeps a trace of recent retired PCs.
module rv32_run_monitor
    import rv32_mon_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              CNT_W          = 32,
    parameter int              TIMEOUT_CYCLES = 5000,
    parameter int              USE_HALT_PC    = 0,
    parameter logic [XLEN-1:0] HALT_PC        = '0,
    parameter int              STUCK_LIMIT    = 4,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR),
    parameter int              TRACE_DEPTH    = 8,
    localparam int             IDX_W          = $clog2(TRACE_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic             store_valid,
    input  logic [XLEN-1:0]  store_addr,
    input  logic [XLEN-1:0]  store_data,
    input  logic [IDX_W-1:0] trace_idx,
    output logic [XLEN-1:0]  trace_pc,
    output logic [IDX_W:0]   trace_count,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [XLEN-1:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam int STREAK_W = $clog2(STUCK_LIMIT + 2);

    mon_state_e        state, state_next;
    mon_status_e       status_r, end_status;
    logic [XLEN-1:0]   end_code;
    logic [XLEN-1:0]   last_pc;
    logic [STREAK_W-1:0] streak, streak_next;
    logic              tohost_hit, halt_hit, stuck_hit, timeout_hit;

    always_comb begin
        tohost_hit  = store_valid && (store_addr == TOHOST_ADDR) && store_data[0];
        halt_hit    = (USE_HALT_PC != 0) && retire_valid && (retire_pc == HALT_PC);
        // A zero streak means no PC has retired yet, so nothing to match against.
        streak_next = ((streak != '0) && (retire_pc == last_pc)) ? streak + STREAK_W'(1)
                                                                 : STREAK_W'(1);
        stuck_hit   = (STUCK_LIMIT != 0) && retire_valid && (streak_next == STREAK_W'(STUCK_LIMIT));
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

        end_status = ST_NONE;
        end_code   = '0;
        if (tohost_hit) begin
            if (store_data == XLEN'(1)) begin
                end_status = ST_PASS;
            end else begin
                end_status = ST_FAIL;
                end_code   = store_data >> 1;
            end
        end else if (halt_hit || stuck_hit) begin
            end_status = ST_PASS;
        end else if (timeout_hit) begin
            end_status = ST_TIMEOUT;
        end

        state_next = state;
        case (state)
            MON_IDLE: state_next = MON_RUN;
            MON_RUN:  if (end_status != ST_NONE) state_next = MON_DONE;
            MON_DONE: state_next = MON_DONE;
            default:  state_next = MON_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= MON_IDLE;
            status_r      <= ST_NONE;
            fail_code     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
            last_pc       <= '0;
            streak        <= '0;
        end else begin
            state <= state_next;
            if (state == MON_RUN) begin
                cycle_count   <= cycle_count + CNT_W'(1);
                instret_count <= instret_count + CNT_W'(retire_valid);
                status_r      <= end_status;
                fail_code     <= end_code;
                if (retire_valid) begin
                    last_pc <= retire_pc;
                    streak  <= streak_next;
                end
            end
        end
    end

    assign status  = status_r;
    assign running = (state == MON_RUN);
    assign done    = (state == MON_DONE);

    rv32_pc_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .reset   (reset),
        .push    (running && retire_valid && !reset),
        .push_pc (retire_pc),
        .rd_idx  (trace_idx),
        .rd_pc   (trace_pc),
        .count   (trace_count)
    );

endmodule

// File: tb/tb_rv32_run_monitor.sv
// Directed bench for rv32_run_monitor: expected run endings are queued by the
// driver and compared by a monitor when done rises; state checks are inline.
module tb_rv32_run_monitor;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;
    localparam int EW    = 2 + XLEN + 2 * CNT_W;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] HALT   = 32'h0000_0300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic        store_valid = 1'b0;
    logic [31:0] store_addr = '0;
    logic [31:0] store_data = '0;
    logic [2:0]  trace_idx = '0;
    logic [31:0] trace_pc;
    logic [3:0]  trace_count;
    logic        running;
    logic        done;
    logic [1:0]  status;
    logic [31:0] fail_code;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    logic          done_seen = 1'b0;
    int            errors = 0;
    int            checks = 0;

    rv32_run_monitor #(
        .XLEN           (XLEN),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (100),
        .USE_HALT_PC    (1),
        .HALT_PC        (HALT),
        .STUCK_LIMIT    (4),
        .TOHOST_ADDR    (TOHOST),
        .TRACE_DEPTH    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .retire_valid  (retire_valid),
        .retire_pc     (retire_pc),
        .store_valid   (store_valid),
        .store_addr    (store_addr),
        .store_data    (store_data),
        .trace_idx     (trace_idx),
        .trace_pc      (trace_pc),
        .trace_count   (trace_count),
        .running       (running),
        .done          (done),
        .status        (status),
        .fail_code     (fail_code),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic rv, input logic [31:0] pc, input logic sv,
                         input logic [31:0] addr, input logic [31:0] data);
        retire_valid = rv;
        retire_pc    = pc;
        store_valid  = sv;
        store_addr   = addr;
        store_data   = data;
        tick();
        retire_valid = 1'b0;
        retire_pc    = '0;
        store_valid  = 1'b0;
        store_addr   = '0;
        store_data   = '0;
    endtask

    // Leaves the monitor in RUN with cycle_count 0.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic expect_end(input logic [1:0] st, input logic [31:0] code,
                              input logic [31:0] cyc, input logic [31:0] ret);
        exp_q.push_back({st, code, cyc, ret});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("wait_done", done, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_running"}, running, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_status"}, status, 0);
        check({tag, "_fail_code"}, fail_code, 0);
        check({tag, "_cycle"}, cycle_count, 0);
        check({tag, "_instret"}, instret_count, 0);
        check({tag, "_trace_count"}, trace_count, 0);
    endtask

    // Scoreboard monitor: one expected ending per rising done
    always @(negedge clk) begin
        if (done && !done_seen) begin
            check("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("sb_status", status, mon_exp[EW-1 -: 2]);
                check("sb_fail_code", fail_code, mon_exp[2*CNT_W+XLEN-1 -: XLEN]);
                check("sb_cycle_count", cycle_count, mon_exp[2*CNT_W-1 -: CNT_W]);
                check("sb_instret", instret_count, mon_exp[CNT_W-1:0]);
            end
        end
        done_seen = done;
    end

    logic [31:0] stuck_seq [12] = '{32'h40, 32'h0, 32'h40, 32'h40, 32'h0, 32'h44,
                                    32'h40, 32'h0, 32'h40, 32'h40, 32'h0, 32'h40};

    initial begin
        // Reset held mid-run, with a passing tohost store that must be ignored
        do_reset(2);
        for (int k = 0; k < 20; k++) cycle(1'b1, 32'(4 * k), 1'b0, '0, '0);
        check("pre_rst_instret", instret_count, 20);
        check("pre_rst_trace_count", trace_count, 8);
        reset        = 1'b1;
        retire_valid = 1'b1;
        retire_pc    = HALT;
        store_valid  = 1'b1;
        store_addr   = TOHOST;
        store_data   = 32'h1;
        tick();
        check_zero("rst_first");
        repeat (2) tick();
        reset        = 1'b0;
        retire_valid = 1'b0;
        store_valid  = 1'b0;
        check_zero("rst_idle");
        tick();
        check("rst_release_running", running, 1);
        check("rst_release_cycle", cycle_count, 0);
        check("rst_release_done", done, 0);

        // Trace wrap: 11 retires of 4*k
        for (int k = 0; k <= 10; k++) cycle(1'b1, 32'(4 * k), 1'b0, '0, '0);
        check("trace_count_sat", trace_count, 8);
        check("trace_instret", instret_count, 11);
        check("trace_cycle", cycle_count, 11);
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
            check("trace_pc", trace_pc, 32'(4 * (10 - i)));
        end
        trace_idx = '0;

        // Tohost pass at cycle 50; non-matching stores before it are ignored
        do_reset(2);
        expect_end(2'd1, 32'd0, 32'd51, 32'd51);
        for (int c = 0; c <= 50; c++) begin
            if (c == 50) check("pass_not_early", done, 0);
            if (c == 10)      cycle(1'b1, 32'(4 * c), 1'b1, TOHOST, 32'h2);
            else if (c == 20) cycle(1'b1, 32'(4 * c), 1'b1, 32'h1004, 32'h1);
            else if (c == 50) cycle(1'b1, 32'(4 * c), 1'b1, TOHOST, 32'h1);
            else              cycle(1'b1, 32'(4 * c), 1'b0, '0, '0);
        end
        check("pass_done_next", done, 1);
        check("pass_running", running, 0);

        // Tohost fail, then everything frozen
        do_reset(2);
        expect_end(2'd2, 32'd10, 32'd6, 32'd1);
        repeat (5) cycle(1'b0, '0, 1'b0, '0, '0);
        cycle(1'b1, 32'h10, 1'b1, TOHOST, 32'h15);
        check("fail_done", done, 1);
        for (int c = 0; c < 10; c++) cycle(1'b1, HALT, 1'b1, TOHOST, 32'h1);
        check("frozen_status", status, 2);
        check("frozen_fail_code", fail_code, 10);
        check("frozen_cycle", cycle_count, 6);
        check("frozen_instret", instret_count, 1);
        check("frozen_trace_count", trace_count, 1);
        check("frozen_trace_pc", trace_pc, 32'h10);
        check("frozen_done", done, 1);
        check("frozen_running", running, 0);

        // Halt PC pass, then tohost fail outranking halt in the same cycle
        do_reset(2);
        expect_end(2'd1, 32'd0, 32'd4, 32'd3);
        cycle(1'b1, 32'h100, 1'b0, '0, '0);
        cycle(1'b1, 32'h104, 1'b0, '0, '0);
        cycle(1'b0, '0, 1'b0, '0, '0);
        cycle(1'b1, HALT, 1'b0, '0, '0);
        check("halt_done", done, 1);
        do_reset(2);
        expect_end(2'd2, 32'd3, 32'd1, 32'd1);
        cycle(1'b1, HALT, 1'b1, TOHOST, 32'h7);
        check("prio_done", done, 1);

        // Stuck PC: streak of 3 broken by 0x44, then four 0x40 with bubbles
        do_reset(2);
        expect_end(2'd1, 32'd0, 32'd12, 32'd8);
        for (int c = 0; c < 12; c++) begin
            if (c == 11) check("stuck_not_early", done, 0);
            cycle(stuck_seq[c] != 0, stuck_seq[c], 1'b0, '0, '0);
        end
        check("stuck_done", done, 1);
        trace_idx = 3'd4;
        #1;
        check("stuck_trace_idx4", trace_pc, 32'h44);
        trace_idx = '0;

        // Timeout, then tohost pass on the timeout cycle
        do_reset(2);
        expect_end(2'd3, 32'd0, 32'd100, 32'd0);
        wait_done(120);
        do_reset(2);
        expect_end(2'd1, 32'd0, 32'd100, 32'd0);
        repeat (99) cycle(1'b0, '0, 1'b0, '0, '0);
        check("timeout_not_early", done, 0);
        cycle(1'b0, '0, 1'b1, TOHOST, 32'h1);
        check("timeout_prio_done", done, 1);

        repeat (2) tick();
        check("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
